// File: rtl/z16_fetch_unit.sv
// z16_fetch_unit: instruction fetch stage of the Z16 CPU.
// Holds the fetch PC, issues 16-bit reads over a req/ack memory port,
// buffers returned words with their PC in a small FIFO and hands them to
// the decoder over valid/ready. A redirect flushes the buffer and restarts
// fetch; a response still owed by memory is drained and dropped.
module z16_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_rdata,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc
);

    localparam int           AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [15:0]    fetch_pc_r, fetch_pc_s;
    logic [15:0]    target_r, target_s;
    logic [15:0]    addr_r, addr_s;
    logic           req_r, req_s;
    logic [AW-1:0]  head_r, head_s;
    logic [AW-1:0]  tail_r, tail_s;
    logic [AW:0]    count_r, count_s;
    logic [15:0]    pc_mem_r    [DEPTH];
    logic [15:0]    instr_mem_r [DEPTH];

    logic           ack_s;
    logic           pop_s;
    logic           push_s;
    logic           pending_s;
    logic [15:0]    redirect_pc_s;

    // Handshake qualifiers shared by the next-state logic.
    always_comb begin
        ack_s         = req_r & i_imem_ack;
        pending_s     = req_r & ~i_imem_ack;
        pop_s         = (count_r != {(AW + 1){1'b0}}) & i_instr_ready;
        push_s        = (state_r == ST_FETCH) & ack_s & ~i_redirect;
        redirect_pc_s = i_redirect_pc & 16'hFFFE;
    end

    // Fetch control: state, fetch PC and saved redirect target.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        target_s   = target_r;
        case (state_r)
            ST_BOOT: begin
                state_s = ST_FETCH;
                if (i_redirect) begin
                    fetch_pc_s = redirect_pc_s;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
            end
            ST_FETCH: begin
                if (i_redirect) begin
                    if (pending_s) begin
                        // memory still owes a word for the old path
                        target_s = redirect_pc_s;
                        state_s  = ST_DRAIN;
                    end else begin
                        fetch_pc_s = redirect_pc_s;
                        state_s    = ST_FETCH;
                    end
                end else if (ack_s) begin
                    fetch_pc_s = fetch_pc_r + 16'd2;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
            end
            ST_DRAIN: begin
                if (i_redirect) begin
                    if (ack_s) begin
                        fetch_pc_s = redirect_pc_s;
                        state_s    = ST_FETCH;
                    end else begin
                        target_s = redirect_pc_s;
                    end
                end else if (ack_s) begin
                    fetch_pc_s = target_r;
                    state_s    = ST_FETCH;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_BOOT;
            end
        endcase
    end

    // Buffer pointers and occupancy; a redirect empties the buffer outright.
    always_comb begin
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
        if (i_redirect) begin
            head_s  = {AW{1'b0}};
            tail_s  = {AW{1'b0}};
            count_s = {(AW + 1){1'b0}};
        end else begin
            if (pop_s) begin
                head_s = head_r + AW'(1);
            end else begin
                head_s = head_r;
            end
            if (push_s) begin
                tail_s = tail_r + AW'(1);
            end else begin
                tail_s = tail_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + (AW + 1)'(1);
                2'b01:   count_s = count_r - (AW + 1)'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // Memory request: held with its address until acked, else raised only
    // when the buffer will have room after this edge.
    always_comb begin
        req_s  = req_r;
        addr_s = addr_r;
        if (pending_s) begin
            req_s  = 1'b1;
            addr_s = addr_r;
        end else begin
            req_s  = (state_s == ST_FETCH) && (count_s < DEPTH_C);
            addr_s = fetch_pc_s;
        end
    end

    // Control and pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_BOOT;
            fetch_pc_r <= RESET_PC;
            target_r   <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
            count_r    <= {(AW + 1){1'b0}};
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            target_r   <= target_s;
            addr_r     <= addr_s;
            req_r      <= req_s;
            head_r     <= head_s;
            tail_r     <= tail_s;
            count_r    <= count_s;
        end
    end

    // Buffer storage of {pc, instr}; written at the tail on push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 16'h0000;
                instr_mem_r[i] <= 16'h0000;
            end
        end else if (push_s) begin
            pc_mem_r[tail_r]    <= fetch_pc_r;
            instr_mem_r[tail_r] <= i_imem_rdata;
        end
    end

    assign o_imem_req    = req_r;
    assign o_imem_addr   = addr_r;
    assign o_instr_valid = (count_r != {(AW + 1){1'b0}});
    assign o_instr       = instr_mem_r[head_r];
    assign o_instr_pc    = pc_mem_r[head_r];

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Testbench for z16_fetch_unit: directed scenarios plus a randomized run
// checked against a stream model (the decoder must see consecutive PCs
// starting at the last redirect target, each carrying the memory word for
// that address).
module tb_z16_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          DEPTH    = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_rdata;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [15:0] o_instr;
    logic [15:0] o_instr_pc;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 0;
    int          mem_wait = 0;
    logic [15:0] mem_salt = 16'hC3A5;

    z16_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ mem_salt;
    endfunction

    // memory model: acks once the request has waited mem_lat cycles
    task automatic drive_mem();
        if (o_imem_req === 1'b1 && mem_wait >= mem_lat) begin
            i_imem_ack   = 1'b1;
            i_imem_rdata = mem_word(o_imem_addr);
        end else begin
            i_imem_ack   = 1'b0;
            i_imem_rdata = 16'h0000;
        end
    endtask

    task automatic adv();
        if (o_imem_req === 1'b1 && i_imem_ack == 1'b0) mem_wait++;
        else mem_wait = 0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_redirect = 1'b0;
        drive_mem();
    endtask

    // leaves the bench at the negedge of the BOOT cycle (cycle 0)
    task automatic do_reset();
        i_rst_n = 1'b0; i_redirect = 1'b0; i_redirect_pc = 16'h0000;
        i_instr_ready = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = 16'h0000;
        mem_wait = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive_mem();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_redirect = 1'b0; i_redirect_pc = 16'h0000;
        i_instr_ready = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = 16'h0000;
        mem_lat = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", o_imem_req); end
        checks++; if (o_imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr got %h exp %h", o_imem_addr, RESET_PC); end
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_instr_valid); end
        checks++; if (o_instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h exp 0000", o_instr); end
        checks++; if (o_instr_pc !== 16'h0000) begin errors++; $display("FAIL rst_instr_pc got %h exp 0000", o_instr_pc); end
        do_reset();
        checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", o_imem_req); end
        adv();
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin errors++; $display("FAIL first_req got %b/%h exp 1/%h", o_imem_req, o_imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [15:0] ea;
        mem_lat = 0;
        do_reset();
        i_instr_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL stream_boot_req got %b exp 0", o_imem_req); end
            end else begin
                ea = 16'(2 * (c - 1));
                checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== ea) begin errors++; $display("FAIL stream_req c%0d got %b/%h exp 1/%h", c, o_imem_req, o_imem_addr, ea); end
            end
            if (c == 1) begin
                checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got valid %b exp 0", o_instr_valid); end
            end else if (c >= 2) begin
                ea = 16'(2 * (c - 2));
                checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== ea || o_instr !== mem_word(ea)) begin errors++; $display("FAIL stream_out c%0d got %b/%h/%h exp 1/%h/%h", c, o_instr_valid, o_instr_pc, o_instr, ea, mem_word(ea)); end
            end
            adv();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ea;
        mem_lat = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            i_instr_ready = (c >= 6) ? 1'b1 : 1'b0;
            if (c >= 3 && c <= 5) begin
                checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL full_req c%0d got %b exp 0", c, o_imem_req); end
                checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0000) begin errors++; $display("FAIL full_head c%0d got %b/%h exp 1/0000", c, o_instr_valid, o_instr_pc); end
            end
            if (c >= 6) begin
                ea = 16'(2 * (c - 6));
                checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== ea || o_instr !== mem_word(ea)) begin errors++; $display("FAIL drain c%0d got %b/%h/%h exp 1/%h/%h", c, o_instr_valid, o_instr_pc, o_instr, ea, mem_word(ea)); end
            end
            adv();
        end
    endtask

    task automatic test_redirect_drain();
        logic found;
        mem_lat = 3;
        do_reset();
        i_instr_ready = 1'b1;
        adv();                          // c1: request for 0 issued
        adv();                          // c2
        i_redirect = 1'b1; i_redirect_pc = 16'h0100;
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0000) begin errors++; $display("FAIL drn_c2 got %b/%h exp 1/0000", o_imem_req, o_imem_addr); end
        adv();                          // c3
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL drn_valid got %b exp 0", o_instr_valid); end
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0000) begin errors++; $display("FAIL drn_hold3 got %b/%h exp 1/0000", o_imem_req, o_imem_addr); end
        adv();                          // c4: discard ack
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0000) begin errors++; $display("FAIL drn_hold4 got %b/%h exp 1/0000", o_imem_req, o_imem_addr); end
        adv();                          // c5: target request
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0100) begin errors++; $display("FAIL drn_target got %b/%h exp 1/0100", o_imem_req, o_imem_addr); end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (o_instr_valid === 1'b1) found = 1'b1;
            else adv();
        end
        checks++; if (!found || o_instr_pc !== 16'h0100 || o_instr !== mem_word(16'h0100)) begin errors++; $display("FAIL drn_first got %b/%h/%h exp 1/0100/%h", found, o_instr_pc, o_instr, mem_word(16'h0100)); end
    endtask

    task automatic test_redirect_same_ack();
        logic found;
        mem_lat = 0;
        do_reset();
        i_instr_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (o_imem_req === 1'b1 && o_imem_addr === 16'h0008) found = 1'b1;
            else adv();
        end
        checks++; if (!found) begin errors++; $display("FAIL sack_wait got no request for 0008 exp one"); end
        i_redirect = 1'b1; i_redirect_pc = 16'h0040;
        adv();
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL sack_flush got valid %b exp 0", o_instr_valid); end
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0040) begin errors++; $display("FAIL sack_req got %b/%h exp 1/0040", o_imem_req, o_imem_addr); end
        adv();
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0040) begin errors++; $display("FAIL sack_first got %b/%h exp 1/0040", o_instr_valid, o_instr_pc); end
        adv();
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0042) begin errors++; $display("FAIL sack_next got %b/%h exp 1/0042", o_instr_valid, o_instr_pc); end
    endtask

    task automatic test_double_redirect_wrap();
        logic found;
        logic [15:0] ea;
        mem_lat = 4;
        do_reset();
        i_instr_ready = 1'b1;
        adv();                          // c1
        adv();                          // c2
        i_redirect = 1'b1; i_redirect_pc = 16'h0200;
        adv();                          // c3
        i_redirect = 1'b1; i_redirect_pc = 16'h0300;
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0000) begin errors++; $display("FAIL dbl_hold got %b/%h exp 1/0000", o_imem_req, o_imem_addr); end
        adv(); adv(); adv();            // c6
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0300) begin errors++; $display("FAIL dbl_target got %b/%h exp 1/0300", o_imem_req, o_imem_addr); end
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (o_instr_valid === 1'b1) found = 1'b1;
            else begin
                checks++; if (o_imem_req === 1'b1 && o_imem_addr === 16'h0200) begin errors++; $display("FAIL dbl_stale got addr %h exp not 0200", o_imem_addr); end
                adv();
            end
        end
        checks++; if (!found || o_instr_pc !== 16'h0300) begin errors++; $display("FAIL dbl_first got %b/%h exp 1/0300", found, o_instr_pc); end
        mem_lat = 0;
        drive_mem();
        i_redirect = 1'b1; i_redirect_pc = 16'hFFFE;
        adv();
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_flush got valid %b exp 0", o_instr_valid); end
        adv();
        for (int k = 0; k < 3; k++) begin
            ea = 16'hFFFE + 16'(2 * k);
            checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== ea || o_instr !== mem_word(ea)) begin errors++; $display("FAIL wrap_seq k%0d got %b/%h exp 1/%h", k, o_instr_valid, o_instr_pc, ea); end
            adv();
        end
    endtask

    task automatic test_reset_mid_drain();
        mem_lat = 0;
        do_reset();
        i_instr_ready = 1'b0;
        adv(); adv(); adv();            // c3: buffer full
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== 16'h0000 || o_imem_req !== 1'b0) begin errors++; $display("FAIL mrst_full got %b/%h/%b exp 1/0000/0", o_instr_valid, o_instr_pc, o_imem_req); end
        mem_lat = 5;
        i_instr_ready = 1'b1;
        adv();                          // c4: room made, slow request for 4
        i_instr_ready = 1'b0;
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0004) begin errors++; $display("FAIL mrst_req got %b/%h exp 1/0004", o_imem_req, o_imem_addr); end
        adv();                          // c5
        i_redirect = 1'b1; i_redirect_pc = 16'h0500;
        adv();                          // c6: in DRAIN
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 16'h0004 || o_instr_valid !== 1'b0) begin errors++; $display("FAIL mrst_drain got %b/%h/%b exp 1/0004/0", o_imem_req, o_imem_addr, o_instr_valid); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_imem_req !== 1'b0 || o_imem_addr !== RESET_PC) begin errors++; $display("FAIL mrst_req_async got %b/%h exp 0/%h", o_imem_req, o_imem_addr, RESET_PC); end
        checks++; if (o_instr_valid !== 1'b0 || o_instr !== 16'h0000 || o_instr_pc !== 16'h0000) begin errors++; $display("FAIL mrst_out_async got %b/%h/%h exp 0/0000/0000", o_instr_valid, o_instr, o_instr_pc); end
        mem_lat = 0;
        do_reset();
        i_instr_ready = 1'b1;
        adv();
        checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin errors++; $display("FAIL mrst_restart got %b/%h exp 1/%h", o_imem_req, o_imem_addr, RESET_PC); end
        adv();
        checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== RESET_PC) begin errors++; $display("FAIL mrst_first got %b/%h exp 1/%h", o_instr_valid, o_instr_pc, RESET_PC); end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] prev_addr;
        logic [15:0] rpc;
        logic        prev_hold;
        logic        prev_redir;
        int          pops;
        mem_salt = 16'($urandom) | 16'h0001;
        mem_lat = 0;
        do_reset();
        exp_pc = RESET_PC; prev_addr = 16'h0000; prev_hold = 1'b0; prev_redir = 1'b0; pops = 0;
        for (int c = 0; c < 3000; c++) begin
            if (mem_wait == 0) begin
                mem_lat = $urandom_range(0, 3);
                drive_mem();
            end
            i_instr_ready = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            i_redirect    = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
            rpc           = 16'($urandom);
            i_redirect_pc = rpc;
            if (prev_hold) begin
                checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_hold c%0d got %b/%h exp 1/%h", c, o_imem_req, o_imem_addr, prev_addr); end
            end
            if (prev_redir) begin
                checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush c%0d got valid %b exp 0", c, o_instr_valid); end
            end
            if (o_instr_valid === 1'b1 && i_instr_ready === 1'b1) begin
                checks++; if (o_instr_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_pop c%0d got %h/%h exp %h/%h", c, o_instr_pc, o_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 16'd2;
                pops++;
            end
            if (i_redirect) exp_pc = rpc & 16'hFFFE;
            prev_hold  = (o_imem_req === 1'b1) && (i_imem_ack == 1'b0);
            prev_addr  = o_imem_addr;
            prev_redir = i_redirect;
            adv();
        end
        checks++; if (pops < 300) begin errors++; $display("FAIL rnd_progress got %0d pops exp >= 300", pops); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_same_ack();
        test_double_redirect_wrap();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
